// File: rtl/iob_regfile_drain_pkg.sv
// Shared definitions for the register-file drain sequencer: FSM state
// encoding, default geometry and the entry-count helper.
package iob_regfile_drain_pkg;

    // Default register-file geometry.
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 21;

    // Binary 2-bit FSM encoding; the values are fixed so that waveforms and
    // any external decoding line up with the documented state numbers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } drain_state_t;

    // Number of register-file entries the sequencer walks.
    function automatic int entry_count(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : iob_regfile_drain_pkg

// File: rtl/iob_reg_re.sv
// Generic data register with asynchronous reset, synchronous reset, clock
// enable and load enable. Priority: arst_i > cke_i gating > rst_i > en_i.
module iob_reg_re #(
    parameter int                DATA_W  = 21,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] r_data;

    // Hold the value unless enabled; either reset returns it to RST_VAL.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_data <= RST_VAL;
        end else if (cke_i) begin
            if (rst_i) begin
                r_data <= RST_VAL;
            end else if (en_i) begin
                // NOTE: sequential state is always assigned with <= so every
                // register samples the pre-edge value of its inputs.
                r_data <= data_i;
            end
        end
    end

    assign data_o = r_data;

endmodule : iob_reg_re

// File: rtl/iob_regfile_drain.sv
// Read-side drain sequencer for the single-port cache register file.
// On an accepted start it snapshots the select mask, walks every entry in
// address order and emits each selected entry on a valid/ready stream,
// tagged with its address. While busy it owns the register-file address.
module iob_regfile_drain
    import iob_regfile_drain_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    input  logic                   start_i,
    input  logic [(2**ADDR_W)-1:0] mask_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ADDR_W-1:0]      rf_addr_o,
    input  logic [DATA_W-1:0]      rf_d_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [ADDR_W-1:0]      m_addr_o,
    output logic [DATA_W-1:0]      m_data_o
);

    localparam int                N_ENTRIES = entry_count(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_PTR  = {ADDR_W{1'b1}};

    // FSM state and registered outputs.
    drain_state_t           r_state;
    logic [ADDR_W-1:0]      r_ptr;
    logic [N_ENTRIES-1:0]   r_mask_q;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_valid;

    // Decoded conditions shared by the FSM and the beat register.
    logic                   w_sel;
    logic                   w_last;
    logic                   w_hs;
    logic                   w_capture;
    logic                   w_arst;
    logic [ADDR_W+DATA_W-1:0] w_beat_d;
    logic [ADDR_W+DATA_W-1:0] w_beat_q;

    assign w_sel     = r_mask_q[r_ptr];
    assign w_last    = (r_ptr == LAST_PTR);
    // Ready only matters while a beat is actually being offered.
    assign w_hs      = r_valid & m_ready_i;
    assign w_capture = (r_state == ST_SCAN) & w_sel;
    assign w_arst    = ~arst_n_i;
    assign w_beat_d  = {r_ptr, rf_d_i};

    // Sequencer FSM: snapshot on start, scan one entry per cycle, stall in
    // OUT until the beat is accepted, then pulse done for one cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            // NOTE: the mask snapshot is a plain register, not storage
            // array, so it gets a reset like every other control flop.
            r_mask_q <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
        end else if (cke_i) begin
            // done is a single-cycle pulse; only the entry into DONE sets it.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mask_q <= mask_i;
                        r_ptr    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_sel) begin
                        r_valid <= 1'b1;
                        r_state <= ST_OUT;
                    end else if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                ST_OUT: begin
                    // Termination is checked before any increment, so the
                    // pointer never wraps past the last entry.
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_ptr   <= r_ptr + 1'b1;
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here: it is not
                    // queued, even in the cycle DONE is exited.
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Beat holding register: loads address and data when a selected entry
    // is scanned and holds them through any amount of backpressure.
    iob_reg_re #(
        .DATA_W (ADDR_W + DATA_W)
    ) u_beat_reg (
        .clk_i  (clk_i),
        .arst_i (w_arst),
        .cke_i  (cke_i),
        .rst_i  (1'b0),
        .en_i   (w_capture),
        .data_i (w_beat_d),
        .data_o (w_beat_q)
    );

    assign m_addr_o  = w_beat_q[ADDR_W+DATA_W-1:DATA_W];
    assign m_data_o  = w_beat_q[DATA_W-1:0];
    assign m_valid_o = r_valid;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    // The address bus is only driven from the pointer while the pass owns it.
    assign rf_addr_o = r_busy ? r_ptr : '0;

endmodule : iob_regfile_drain

// File: tb/tb_iob_regfile_drain.sv
// Directed bench for iob_regfile_drain (ADDR_W=2, DATA_W=21). The model
// register file returns 0x00A00 + address.
module tb_iob_regfile_drain;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 21;

    logic              clk_i = 1'b0;
    logic              arst_n_i;
    logic              cke_i;
    logic              start_i;
    logic [3:0]        mask_i;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W-1:0] rf_addr_o;
    logic [DATA_W-1:0] rf_d_i;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_data_o;

    int n_checks = 0;
    int n_errors = 0;

    // Capture of one pass, cycle index 0 = sample right after accepting edge.
    logic [ADDR_W-1:0] cap_addr [8];
    logic [DATA_W-1:0] cap_data [8];
    int                cap_cyc  [8];
    int                cap_n;
    int                cap_done_cyc;
    int                cap_done_cnt;
    int                cap_busy_cnt;
    bit                cap_end;

    iob_regfile_drain #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .cke_i     (cke_i),
        .start_i   (start_i),
        .mask_i    (mask_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rf_addr_o (rf_addr_o),
        .rf_d_i    (rf_d_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_addr_o  (m_addr_o),
        .m_data_o  (m_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational register-file model.
    assign rf_d_i = 21'h00A00 + {19'b0, rf_addr_o};

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Run one pass with ready as currently driven. cke_lo_at/cke_lo_len
    // freeze the DUT for a window; disturb pulses start and clears mask
    // while the first beat is offered.
    task automatic do_pass(input logic [3:0] mask, input int budget,
                           input int cke_lo_at, input int cke_lo_len,
                           input bit disturb);
        cap_n = 0; cap_done_cyc = -1; cap_done_cnt = 0;
        cap_busy_cnt = 0; cap_end = 1'b0;
        mask_i  = mask;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c == cke_lo_at) cke_i = 1'b0;
            if (c == cke_lo_at + cke_lo_len) cke_i = 1'b1;
            if (disturb && c == 2) start_i = 1'b0;
            if (busy_o) cap_busy_cnt++;
            if (done_o) begin
                cap_done_cnt++;
                if (cap_done_cyc < 0) cap_done_cyc = c;
            end
            if (m_valid_o && m_ready_i && cke_i && cap_n < 8) begin
                cap_addr[cap_n] = m_addr_o;
                cap_data[cap_n] = m_data_o;
                cap_cyc[cap_n]  = c;
                cap_n++;
            end
            if (disturb && c == 1) begin
                start_i = 1'b1;
                mask_i  = 4'b0000;
            end
            if (c > 0 && !busy_o) begin
                cap_end = 1'b1;
                break;
            end
            step();
        end
        cke_i   = 1'b1;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0; cke_i = 1'b1; start_i = 1'b0;
        mask_i = 4'b0; m_ready_i = 1'b1;
        #12;
        n_checks++;
        if ({busy_o, done_o, m_valid_o} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy/done/valid=%b expected 000", {busy_o, done_o, m_valid_o});
        end
        n_checks++;
        if ({rf_addr_o, m_addr_o, m_data_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: rf_addr=%0h m_addr=%0h m_data=%0h expected 0", rf_addr_o, m_addr_o, m_data_o);
        end
        #11 arst_n_i = 1'b1;
        step();
    endtask

    task automatic test_full_mask();
        int exp_cyc [4] = '{1, 3, 5, 7};
        m_ready_i = 1'b1;
        do_pass(4'b1111, 40, -10, 0, 1'b0);
        n_checks++;
        if (cap_end !== 1'b1 || cap_n !== 4) begin
            n_errors++;
            $display("FAIL full_beats: end=%0d beats=%0d expected 1/4", cap_end, cap_n);
        end
        for (int i = 0; i < 4 && i < cap_n; i++) begin
            n_checks++;
            if (cap_addr[i] !== 2'(i) || cap_data[i] !== 21'h00A00 + 21'(i) || cap_cyc[i] !== exp_cyc[i]) begin
                n_errors++;
                $display("FAIL full_beat%0d: addr=%0h data=%0h cyc=%0d expected %0h/%0h/%0d",
                         i, cap_addr[i], cap_data[i], cap_cyc[i], i, 21'h00A00 + 21'(i), exp_cyc[i]);
            end
        end
        n_checks++;
        if (cap_done_cyc !== 8 || cap_done_cnt !== 1) begin
            n_errors++;
            $display("FAIL full_done: cyc=%0d count=%0d expected 8/1", cap_done_cyc, cap_done_cnt);
        end
    endtask

    task automatic test_sparse_mask();
        m_ready_i = 1'b1;
        do_pass(4'b1010, 40, -10, 0, 1'b0);
        n_checks++;
        if (cap_end !== 1'b1 || cap_n !== 2) begin
            n_errors++;
            $display("FAIL sparse_beats: end=%0d beats=%0d expected 1/2", cap_end, cap_n);
        end
        n_checks++;
        if (cap_addr[0] !== 2'd1 || cap_data[0] !== 21'h00A01 || cap_cyc[0] !== 2) begin
            n_errors++;
            $display("FAIL sparse_beat0: addr=%0h data=%0h cyc=%0d expected 1/a01/2", cap_addr[0], cap_data[0], cap_cyc[0]);
        end
        n_checks++;
        if (cap_addr[1] !== 2'd3 || cap_data[1] !== 21'h00A03 || cap_cyc[1] !== 5) begin
            n_errors++;
            $display("FAIL sparse_beat1: addr=%0h data=%0h cyc=%0d expected 3/a03/5", cap_addr[1], cap_data[1], cap_cyc[1]);
        end
        // done is visible right after the edge that completes the last beat.
        n_checks++;
        if (cap_done_cyc !== 6 || cap_done_cnt !== 1) begin
            n_errors++;
            $display("FAIL sparse_done: cyc=%0d count=%0d expected 6/1", cap_done_cyc, cap_done_cnt);
        end
    endtask

    task automatic test_empty_mask();
        m_ready_i = 1'b1;
        do_pass(4'b0000, 40, -10, 0, 1'b0);
        n_checks++;
        if (cap_end !== 1'b1 || cap_n !== 0) begin
            n_errors++;
            $display("FAIL empty_beats: end=%0d beats=%0d expected 1/0", cap_end, cap_n);
        end
        // Fifth cycle after the accepting edge (index 4), busy for 5 cycles.
        n_checks++;
        if (cap_done_cyc !== 4 || cap_busy_cnt !== 5) begin
            n_errors++;
            $display("FAIL empty_timing: done_cyc=%0d busy=%0d expected 4/5", cap_done_cyc, cap_busy_cnt);
        end
    endtask

    task automatic test_backpressure();
        int stable = 0;
        int done_c = -1;
        m_ready_i = 1'b0;
        mask_i    = 4'b0001;
        start_i   = 1'b1;
        step();
        start_i = 1'b0;
        step();
        // Samples 1..7: ready held low, beat must not move.
        for (int c = 1; c <= 7; c++) begin
            if (m_valid_o === 1'b1 && m_addr_o === 2'd0 && m_data_o === 21'h00A00) stable++;
            if (c < 7) step();
        end
        n_checks++;
        if (stable !== 7) begin
            n_errors++;
            $display("FAIL bp_stable: stable_cycles=%0d expected 7", stable);
        end
        m_ready_i = 1'b1;
        step();
        n_checks++;
        if (m_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_handshake: valid=%b expected 0", m_valid_o);
        end
        for (int c = 8; c < 20; c++) begin
            if (done_o) begin
                done_c = c;
                break;
            end
            step();
        end
        n_checks++;
        if (done_c !== 11) begin
            n_errors++;
            $display("FAIL bp_done: cyc=%0d expected 11", done_c);
        end
        step();
    endtask

    task automatic test_ignored_inputs();
        int extra_busy = 0;
        m_ready_i = 1'b1;
        do_pass(4'b1111, 40, -10, 0, 1'b1);
        n_checks++;
        if (cap_end !== 1'b1 || cap_n !== 4 || cap_done_cyc !== 8) begin
            n_errors++;
            $display("FAIL ign_pass: end=%0d beats=%0d done_cyc=%0d expected 1/4/8", cap_end, cap_n, cap_done_cyc);
        end
        n_checks++;
        if (cap_addr[3] !== 2'd3 || cap_data[3] !== 21'h00A03) begin
            n_errors++;
            $display("FAIL ign_last: addr=%0h data=%0h expected 3/a03", cap_addr[3], cap_data[3]);
        end
        for (int c = 0; c < 6; c++) begin
            if (busy_o || m_valid_o) extra_busy++;
            step();
        end
        n_checks++;
        if (extra_busy !== 0) begin
            n_errors++;
            $display("FAIL ign_no_second: busy_cycles=%0d expected 0", extra_busy);
        end
    endtask

    task automatic test_cke_stretch();
        int exp_cyc [4] = '{1, 6, 8, 10};
        m_ready_i = 1'b1;
        do_pass(4'b1111, 40, 2, 3, 1'b0);
        n_checks++;
        if (cap_end !== 1'b1 || cap_n !== 4) begin
            n_errors++;
            $display("FAIL cke_beats: end=%0d beats=%0d expected 1/4", cap_end, cap_n);
        end
        for (int i = 0; i < 4 && i < cap_n; i++) begin
            n_checks++;
            if (cap_addr[i] !== 2'(i) || cap_cyc[i] !== exp_cyc[i]) begin
                n_errors++;
                $display("FAIL cke_beat%0d: addr=%0h cyc=%0d expected %0h/%0d", i, cap_addr[i], cap_cyc[i], i, exp_cyc[i]);
            end
        end
        n_checks++;
        if (cap_done_cyc !== 11 || cap_busy_cnt !== 12) begin
            n_errors++;
            $display("FAIL cke_stretch: done_cyc=%0d busy=%0d expected 11/12", cap_done_cyc, cap_busy_cnt);
        end
    endtask

    task automatic test_reset_mid_beat();
        m_ready_i = 1'b0;
        mask_i    = 4'b1100;
        start_i   = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (m_valid_o !== 1'b1 || m_addr_o !== 2'd2) begin
            n_errors++;
            $display("FAIL rst_pre: valid=%b addr=%0h expected 1/2", m_valid_o, m_addr_o);
        end
        #2 arst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, m_valid_o, rf_addr_o, m_addr_o, m_data_o} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid: busy=%b done=%b valid=%b rf_addr=%0h addr=%0h data=%0h expected all 0",
                     busy_o, done_o, m_valid_o, rf_addr_o, m_addr_o, m_data_o);
        end
        n_checks++;
        if (dut.r_state !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_state: state=%0d expected 0", dut.r_state);
        end
        #3 arst_n_i = 1'b1;
        step();
        m_ready_i = 1'b1;
        do_pass(4'b0101, 40, -10, 0, 1'b0);
        n_checks++;
        if (cap_n !== 2 || cap_addr[0] !== 2'd0 || cap_data[0] !== 21'h00A00 || cap_cyc[0] !== 1) begin
            n_errors++;
            $display("FAIL rst_redrain: beats=%0d addr=%0h data=%0h cyc=%0d expected 2/0/a00/1",
                     cap_n, cap_addr[0], cap_data[0], cap_cyc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        step();
        test_sparse_mask();
        step();
        test_empty_mask();
        step();
        test_backpressure();
        test_ignored_inputs();
        test_cke_stretch();
        step();
        test_reset_mid_beat();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_iob_regfile_drain
